fma_issue_arbiter: RTL

Shares one fpfma datapath between NREQ independent requesters. The datapath is wrapped externally in LAT register stages.
- Round-robin arbitration, one operation per cycle.
- Registers the granted operands onto the datapath inputs and tracks requester IDs through the pipeline.
- Captures results into a response FIFO with valid/ready back-pressure.
- A reservation counter keeps in-flight results from ever overflowing the FIFO.

---
 rtl/fma_issue_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fma_issue_arbiter.sv
// Purpose: round-robin share of one external fpfma pipeline between NREQ requesters, results returned via a response FIFO.
// Latency: grant in cycle T -> fma_issue in T+1 -> result captured at end of T+1+LAT -> rsp_valid from T+2+LAT.
// Backpressure: rsp_valid/rsp_ready on responses; grants stop while reserved slots reach DEPTH. Option: FMA_ARB_PERF_CNT_EN adds perf counters.
module fma_issue_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*WIDTH-1:0] req_c,
   input  logic [2*NREQ-1:0]   req_rnd,
   output logic [WIDTH-1:0]    fma_a,
   output logic [WIDTH-1:0]    fma_b,
   output logic [WIDTH-1:0]    fma_c,
   output logic [1:0]          fma_rnd,
   output logic                fma_issue,
   input  logic [WIDTH-1:0]    fma_result,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [WIDTH-1:0]    rsp_result
`ifdef FMA_ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_issue_cnt,
   output logic [31:0]         perf_stall_cnt
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   gnt_id;
   logic             gnt;
   logic [CW-1:0]    reserved;
   logic [IDW-1:0]   iss_id;
   logic [LAT-1:0]   pipe_vld;
   logic [IDW-1:0]   pipe_id [LAT];
   logic [WIDTH-1:0] fifo_res [DEPTH];
   logic [IDW-1:0]   fifo_id [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    fifo_cnt;
   logic             push;
   logic             pop;

   // Requester index k positions after the pointer, wrapping modulo NREQ.
   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign push      = pipe_vld[LAT-1];
   assign rsp_valid = (fifo_cnt != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_id    = fifo_id[rd_ptr];
   assign rsp_result = fifo_res[rd_ptr];

   // Round-robin search from the pointer; gated by the registered reservation count only, so rsp_ready never reaches req_ready.
   always_comb begin
      req_ready = '0;
      gnt       = 1'b0;
      gnt_id    = '0;
      if (rst_n && (reserved < CW'(DEPTH))) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!gnt && req_valid[rr_idx(rr_ptr, k)]) begin
               gnt                          = 1'b1;
               gnt_id                       = rr_idx(rr_ptr, k);
               req_ready[rr_idx(rr_ptr, k)] = 1'b1;
            end
         end
      end
   end

   // Issue registers, RR pointer and reservation count; operands hold when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         reserved  <= '0;
         iss_id    <= '0;
         fma_issue <= 1'b0;
         fma_a     <= '0;
         fma_b     <= '0;
         fma_c     <= '0;
         fma_rnd   <= '0;
      end else begin
         fma_issue <= gnt;
         if (gnt) begin
            rr_ptr  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            iss_id  <= gnt_id;
            fma_a   <= req_a[gnt_id*WIDTH +: WIDTH];
            fma_b   <= req_b[gnt_id*WIDTH +: WIDTH];
            fma_c   <= req_c[gnt_id*WIDTH +: WIDTH];
            fma_rnd <= req_rnd[gnt_id*2 +: 2];
         end
         case ({gnt, pop})
            2'b10:   reserved <= reserved + CW'(1);
            2'b01:   reserved <= reserved - CW'(1);
            default: reserved <= reserved;
         endcase
      end
   end

   // {valid, id} shift pipe that mirrors the datapath depth so each result is tagged with its requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int k = 0; k < LAT; k++) pipe_id[k] <= '0;
      end else begin
         pipe_vld[0] <= fma_issue;
         pipe_id[0]  <= iss_id;
         for (int k = 1; k < LAT; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_id[k]  <= pipe_id[k-1];
         end
      end
   end

   // Response FIFO, first-word-fall-through from a registered head; storage cleared so outputs read zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            fifo_res[k] <= '0;
            fifo_id[k]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_res[wr_ptr] <= fma_result;
            fifo_id[wr_ptr]  <= pipe_id[LAT-1];
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // The reservation count must make a push into a full FIFO unreachable.
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_cnt == CW'(DEPTH)));

`ifdef FMA_ARB_PERF_CNT_EN
   // Saturating counters for issued ops and cycles stalled on a full reservation window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (gnt && perf_issue_cnt != 32'hFFFF_FFFF)
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if ((|req_valid) && reserved == CW'(DEPTH) && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
